// File: rtl/bram_grid_reader_pkg.sv
// Shared types for the grid BRAM read sequencer.
package bram_grid_reader_pkg;

    // Tag fields are sized for the largest supported grid (up to 256 x 256).
    localparam int unsigned TAG_XW = 8;
    localparam int unsigned TAG_YW = 8;

    typedef struct packed {
        logic [TAG_XW-1:0] x;
        logic [TAG_YW-1:0] y;
        logic              last;
    } cell_tag_t;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain
    } state_e;

    function automatic int unsigned n_cells(input int unsigned rows, input int unsigned cols);
        return rows * cols;
    endfunction

endpackage

// File: rtl/bram_grid_reader_skid_fifo.sv
// Two-entry valid/ready skid buffer; the head entry drives the outputs.
module bram_grid_reader_skid_fifo #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count_q != 2'd0);
    // A pop in the same cycle frees the slot, so pushing into a full buffer is legal then.
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    assign valid = (count_q != 2'd0);
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count_q == 2'd2) && !do_pop));

endmodule

// File: rtl/bram_grid_reader.sv
// Raster-scan read sequencer for the 1-bit grid BRAM, presenting cells as a tagged stream.
module bram_grid_reader
    import bram_grid_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned COLS   = 141,
    parameter int unsigned ROWS   = 141,
    parameter int unsigned XW     = 8,
    parameter int unsigned YW     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic [XW-1:0]     out_x,
    output logic [YW-1:0]     out_y,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NCells   = n_cells(ROWS, COLS);
    localparam int unsigned EntryW   = 1 + $bits(cell_tag_t);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NCells - 1);
    localparam logic [XW-1:0]     LastX    = XW'(COLS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;           // next address to issue
    logic [ADDR_W-1:0] last_addr_q, last_addr_d; // most recently issued address
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    cell_tag_t         tag_q, tag_d;
    logic              inflight_q;
    logic              done_q, done_d;

    logic              issue;
    logic              pop;
    logic              is_last_addr;
    logic [1:0]        occ;
    logic [2:0]        fill;
    logic              fifo_valid;
    logic [EntryW-1:0] fifo_head;
    cell_tag_t         head_tag;

    assign pop          = fifo_valid && out_ready;
    assign is_last_addr = (addr_q == LastAddr);
    // Occupancy the buffer will have after this edge, before counting a new issue.
    assign fill  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = (state_q == StScan) && (fill < 3'd2);
    assign rd_addr = issue ? addr_q : last_addr_q;

    bram_grid_reader_skid_fifo #(
        .W(EntryW)
    ) u_grid_skid_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight_q),
        .push_data({rd_val, tag_q}),
        .pop      (pop),
        .valid    (fifo_valid),
        .head     (fifo_head),
        .count    (occ)
    );

    assign head_tag  = fifo_head[EntryW-2:0];
    assign out_valid = fifo_valid;
    assign out_bit   = fifo_head[EntryW-1];
    assign out_x     = XW'(head_tag.x);
    assign out_y     = YW'(head_tag.y);
    assign out_last  = fifo_valid && head_tag.last;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

    // Next-state: scan sequencing, address/coordinate counters and in-flight tag.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        x_d         = x_q;
        y_d         = y_q;
        tag_d       = tag_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StScan;
                    addr_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            StScan: begin
                if (issue) begin
                    last_addr_d = addr_q;
                    tag_d.x     = TAG_XW'(x_q);
                    tag_d.y     = TAG_YW'(y_q);
                    tag_d.last  = is_last_addr;
                    if (is_last_addr) begin
                        state_d = StDrain;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (x_q == LastX) begin
                            x_d = '0;
                            y_d = y_q + YW'(1);
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                    end
                end
            end
            StDrain: begin
                if (pop && head_tag.last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            last_addr_q <= '0;
            x_q         <= '0;
            y_q         <= '0;
            tag_q       <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            x_q         <= x_d;
            y_q         <= y_d;
            tag_q       <= tag_d;
            inflight_q  <= issue;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_bram_grid_reader.sv
// Self-checking bench: 4x3 grid reader with a scan-order model, plus a 1x1 grid instance.
module tb_bram_grid_reader;

    localparam int unsigned COLS   = 4;
    localparam int unsigned ROWS   = 3;
    localparam int unsigned NC     = COLS * ROWS;
    localparam int unsigned ADDR_W = 17;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4x3 instance
    logic              start_a     = 1'b0;
    logic              out_ready_a = 1'b1;
    logic [ADDR_W-1:0] rd_addr_a;
    logic              rd_val_a;
    logic              out_valid_a, out_bit_a, out_last_a, busy_a, done_a;
    logic [7:0]        out_x_a, out_y_a;
    logic              mem_a [NC];

    // 1x1 instance
    logic              start_b = 1'b0;
    logic [ADDR_W-1:0] rd_addr_b;
    logic              rd_val_b;
    logic              out_valid_b, out_bit_b, out_last_b, busy_b, done_b;
    logic [7:0]        out_x_b, out_y_b;

    bram_grid_reader #(.ADDR_W(ADDR_W), .COLS(COLS), .ROWS(ROWS), .XW(8), .YW(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .rd_addr(rd_addr_a), .rd_val(rd_val_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_bit(out_bit_a),
        .out_x(out_x_a), .out_y(out_y_a), .out_last(out_last_a), .busy(busy_a), .done(done_a)
    );

    bram_grid_reader #(.ADDR_W(ADDR_W), .COLS(1), .ROWS(1), .XW(8), .YW(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .rd_addr(rd_addr_b), .rd_val(rd_val_b),
        .out_valid(out_valid_b), .out_ready(1'b1), .out_bit(out_bit_b),
        .out_x(out_x_b), .out_y(out_y_b), .out_last(out_last_b), .busy(busy_b), .done(done_b)
    );

    // Registered-read RAM models (no reset on the read data).
    always @(posedge clk) begin
        rd_val_a <= (rd_addr_a < ADDR_W'(NC)) ? mem_a[rd_addr_a[3:0]] : 1'b0;
        rd_val_b <= (rd_addr_b == '0);
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stream model for the 4x3 instance: beat n is cell (n % COLS, n / COLS).
    int   beat_a      = 0;
    int   scans_a     = 0;
    logic last_acc_a  = 1'b0;
    logic exp_busy_a  = 1'b0;
    logic prev_stall  = 1'b0;
    logic [17:0] prev_out = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                beat_a     = 0;
                last_acc_a = 1'b0;
                exp_busy_a = 1'b0;
                prev_stall = 1'b0;
            end else begin
                int ex, ey;
                logic [17:0] cur;
                cur = {out_bit_a, out_x_a, out_y_a, out_last_a};
                chk("m_done", 32'(done_a), 32'(last_acc_a));
                chk("m_busy", 32'(busy_a), 32'(exp_busy_a));
                if (!exp_busy_a) chk("m_idle_valid", 32'(out_valid_a), 0);
                if (prev_stall) begin
                    chk("m_stall_valid", 32'(out_valid_a), 1);
                    chk("m_stall_hold", 32'(cur), 32'(prev_out));
                end
                last_acc_a = 1'b0;
                if (out_valid_a && out_ready_a) begin
                    ex = beat_a % COLS;
                    ey = beat_a / COLS;
                    chk("m_x", 32'(out_x_a), ex);
                    chk("m_y", 32'(out_y_a), ey);
                    chk("m_bit", 32'(out_bit_a), (ex + ey) % 2);
                    chk("m_last", 32'(out_last_a), (beat_a == NC - 1) ? 1 : 0);
                    if (beat_a == NC - 1) begin
                        last_acc_a = 1'b1;
                        beat_a     = 0;
                        scans_a++;
                    end else begin
                        beat_a++;
                    end
                end
                if (last_acc_a) exp_busy_a = 1'b0;
                else if (!exp_busy_a && start_a) exp_busy_a = 1'b1;
                prev_stall = out_valid_a && !out_ready_a;
                prev_out   = cur;
            end
        end
    end

    task automatic pulse_start_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    task automatic test_stream();
        logic [NC-1:0] bits = '0;
        int first_v = -1, last_v = -1, nvalid = 0, done_c = -1;
        out_ready_a = 1'b1;
        pulse_start_a();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid_a) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                nvalid++;
                bits = {bits[NC-2:0], out_bit_a};
            end
            if (done_a && done_c < 0) done_c = c;
            if (c == 12) chk("t1_last_early", 32'(out_last_a), 0);
            if (c == 13) chk("t1_last_final", 32'(out_last_a), 1);
        end
        chk("t1_first_valid", first_v, 2);
        chk("t1_last_valid", last_v, 13);
        chk("t1_beats", nvalid, 12);
        chk("t1_done_cycle", done_c, 14);
        chk("t1_bits", 32'(bits), 32'(12'b0101_1010_0101));
        chk("t1_busy_after", 32'(busy_a), 0);
    endtask

    task automatic test_backpressure();
        logic [15:0] pat = 16'b1001_1011_0010_1101;
        logic [NC-1:0] bits = '0;
        int got = 0, n = 0;
        pulse_start_a();
        for (int c = 0; c < 200 && got == 0; c++) begin
            out_ready_a = pat[c % 16];
            @(negedge clk);
            if (out_valid_a && out_ready_a) begin
                bits = {bits[NC-2:0], out_bit_a};
                n++;
            end
            if (done_a) got = 1;
            @(posedge clk); #1;
        end
        out_ready_a = 1'b1;
        chk("t2_done_seen", got, 1);
        chk("t2_beats", n, 12);
        chk("t2_bits", 32'(bits), 32'(12'b0101_1010_0101));
    endtask

    task automatic test_stall();
        int got = 0, n = 0, gap = 0;
        out_ready_a = 1'b0;
        pulse_start_a();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) chk("t3_addr_first", 32'(rd_addr_a), 0);
            else chk("t3_addr_frozen", 32'(rd_addr_a), 1);
        end
        chk("t3_hold_valid", 32'(out_valid_a), 1);
        chk("t3_hold_x", 32'(out_x_a), 0);
        chk("t3_hold_y", 32'(out_y_a), 0);
        @(posedge clk); #1 out_ready_a = 1'b1;
        for (int c = 0; c < 100 && got == 0; c++) begin
            @(negedge clk);
            if (done_a) begin
                got = 1;
                chk("t3_done_offset", c, 12);
            end else if (out_valid_a) n++;
            else gap++;
        end
        chk("t3_done_seen", got, 1);
        chk("t3_beats", n, 12);
        chk("t3_gaps", gap, 0);
    endtask

    task automatic test_reset();
        int n = 0, got = 0;
        out_ready_a = 1'b1;
        pulse_start_a();
        for (int c = 0; c < 50 && n < 5; c++) begin
            @(negedge clk);
            if (out_valid_a && out_ready_a) n++;
        end
        chk("t4_beats_pre", n, 5);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("t4_rd_addr", 32'(rd_addr_a), 0);
        chk("t4_valid", 32'(out_valid_a), 0);
        chk("t4_bit", 32'(out_bit_a), 0);
        chk("t4_x", 32'(out_x_a), 0);
        chk("t4_y", 32'(out_y_a), 0);
        chk("t4_last", 32'(out_last_a), 0);
        chk("t4_busy", 32'(busy_a), 0);
        chk("t4_done", 32'(done_a), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_no_done", 32'(done_a), 0);
            chk("t4_quiet", 32'(out_valid_a), 0);
        end
        n = 0;
        pulse_start_a();
        for (int c = 0; c < 100 && got == 0; c++) begin
            @(negedge clk);
            if (done_a) got = 1;
            else if (out_valid_a && out_ready_a) begin
                if (n == 0) begin
                    chk("t4_restart_x", 32'(out_x_a), 0);
                    chk("t4_restart_y", 32'(out_y_a), 0);
                end
                n++;
            end
        end
        chk("t4_done_seen", got, 1);
        chk("t4_beats", n, 12);
    endtask

    task automatic test_double_start();
        int acc = 0, dones = 0, done_c = -1, resume_c = -1;
        logic nxt;
        out_ready_a = 1'b1;
        pulse_start_a();
        for (int c = 0; c < 100 && dones < 2; c++) begin
            @(negedge clk);
            nxt = 1'b0;
            if (done_a) begin
                dones++;
                if (done_c < 0) done_c = c;
            end
            if (out_valid_a && out_ready_a) begin
                acc++;
                if (acc == 3 || acc == 12) nxt = 1'b1;
                if (acc == 13) resume_c = c;
            end
            @(posedge clk); #1 start_a = nxt;
        end
        start_a = 1'b0;
        chk("t5_dones", dones, 2);
        chk("t5_beats", acc, 24);
        chk("t5_resume_gap", resume_c - done_c, 3);
    endtask

    task automatic test_single_cell();
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 1) chk("t6_valid_c1", 32'(out_valid_b), 0);
            if (c == 2) begin
                chk("t6_valid", 32'(out_valid_b), 1);
                chk("t6_bit", 32'(out_bit_b), 1);
                chk("t6_x", 32'(out_x_b), 0);
                chk("t6_y", 32'(out_y_b), 0);
                chk("t6_last", 32'(out_last_b), 1);
                chk("t6_done_early", 32'(done_b), 0);
            end
            if (c == 3) begin
                chk("t6_done", 32'(done_b), 1);
                chk("t6_valid_after", 32'(out_valid_b), 0);
            end
            if (c == 4) begin
                chk("t6_done_pulse", 32'(done_b), 0);
                chk("t6_busy_after", 32'(busy_b), 0);
            end
        end
    endtask

    initial begin
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                mem_a[y * COLS + x] = 1'((x + y) & 1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_addr", 32'(rd_addr_a), 0);
        chk("rst_valid", 32'(out_valid_a), 0);
        chk("rst_bit", 32'(out_bit_a), 0);
        chk("rst_x", 32'(out_x_a), 0);
        chk("rst_y", 32'(out_y_a), 0);
        chk("rst_last", 32'(out_last_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        test_stream();
        test_backpressure();
        test_stall();
        test_reset();
        test_double_start();
        test_single_cell();
        repeat (3) @(negedge clk);
        chk("scans_completed", 32'(scans_a), 6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bram_grid_reader.md
Name: bram_grid_reader

Overview:
- Read-side sequencer for the 1-bit simple dual-port grid BRAM.
- Raster-scans a ROWS x COLS bit grid (row-major, address = y*COLS + x) and drives the RAM read address.
- Absorbs the RAM's fixed 1-cycle read latency and presents each cell as a valid/ready stream tagged with (x, y) to downstream solver logic.
- Sustains one cell per cycle when downstream is always ready.

Parameters:
ADDR_W, 17, RAM address width; must satisfy ROWS*COLS <= 2**ADDR_W
COLS, 141, grid width in cells (>= 1)
ROWS, 141, grid height in cells (>= 1)
XW, 8, width of x coordinate; 2**XW >= COLS
YW, 8, width of y coordinate; 2**YW >= ROWS

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a scan when idle, ignored while busy
rd_addr  out  ADDR_W  read address to RAM; sampled by RAM on the same clk edge
rd_val  in  1  RAM registered read data; valid the cycle after an issued address
out_valid  out  1  out_bit/out_x/out_y/out_last hold a cell
out_ready  in  1  downstream accepts when out_valid && out_ready
out_bit  out  1  cell value
out_x  out  XW  cell column
out_y  out  YW  cell row
out_last  out  1  set on cell (COLS-1, ROWS-1)
busy  out  1  scan in progress (from start accept until last cell accepted)
done  out  1  one-cycle pulse the cycle after the last cell is accepted

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: rd_addr=0, out_valid=0, out_bit=0, out_x=0, out_y=0, out_last=0, busy=0, done=0. All issue counters, the in-flight flag and the buffer are cleared.
- rd_val is not reset by the RAM. The reader must track validity itself and never forward rd_val without a matching issue one cycle earlier.
- FSM states:
  - IDLE: start=1 -> SCAN; issue counters cleared to (0,0), addr 0.
  - SCAN: issues reads until all ROWS*COLS addresses have been issued -> DRAIN.
  - DRAIN: waits until the buffer is empty and the last cell is accepted -> IDLE, with done=1 for one cycle.
- Issue rule: a read issues in cycle t when in SCAN and occ + inflight - pop < 2.
  - occ: output buffer occupancy (0..2).
  - inflight: read issued in t-1.
  - pop: out_valid && out_ready in t.
  - Issued address is rd_addr in cycle t.
  - Return captured at edge t+1, appearing in the buffer at t+2 along with issue-time (x, y).
- Address/coords: a linear address counter increments by 1 per issue. x wraps COLS-1 -> 0 with y += 1. No multiplier.
- Coordinates and last flag travel with the in-flight read (1-deep tag register).
- Output buffer: 2-entry skid FIFO, head drives out_*. out_* stable while out_valid && !out_ready.
- Throughput: out_ready held 1 -> first out_valid 2 cycles after start, then one cell per cycle, ROWS*COLS consecutive valid cycles.
- Backpressure:
  - Any out_ready pattern must yield no loss, no duplication, and no reordering.
  - Buffer never exceeds 2.
  - A buffer overflow is a design error (assert).
- Simultaneous push and pop on the buffer is legal at any occupancy, including full (pop frees the slot).
- start while busy: ignored, no restart.
- start in the same cycle as done: accepted (IDLE is entered that cycle).
- COLS=1 or ROWS=1: scan degenerates correctly; 1x1 grid gives one cell with out_last=1.
- Reset mid-scan: immediate return to IDLE, out_valid=0, no done pulse. An in-flight read is discarded.
- rd_addr after the final issue: holds the last address. Its value in IDLE is don't-care except after reset (0).

Decomposition:
- Shared package holds:
  - cell_tag struct {x[XW], y[YW], last}.
  - FSM state enum {IDLE, SCAN, DRAIN}.
  - localparam N_CELLS = ROWS*COLS.
- One natural sub-module: grid_skid_fifo, a 2-entry valid/ready buffer carrying {bit, cell_tag}, instantiated once.
- The BRAM itself is instantiated by the parent, not inside this block.

Test Plan:
- Setup: COLS=4, ROWS=3, RAM preloaded with cell = (x+y)&1, out_ready=1, start pulse. Expect:
  - out_valid from cycle 2, 12 consecutive beats.
  - Bits 0101,1010,0101 with (x, y) sequence (0,0)..(3,2).
  - out_last only on beat 12; done exactly one cycle after it; busy low after.
- Same grid, out_ready toggling 1,0,0,1 pseudo-randomly. Expect:
  - Identical 12-beat sequence to the previous test.
  - out_* stable during stalls.
  - Buffer occupancy never >2.
- out_ready=0 for 20 cycles after start. Expect:
  - Exactly 2 reads issued, then rd_addr frozen at 1.
  - On release, the stream resumes from (0,0) with no gaps after the buffer drains.
- Reset mid-scan: assert rst_n=0 at beat 5 for 1 cycle. Expect:
  - All outputs at reset values, no done.
  - A new start rescans from (0,0) and completes 12 beats.
- start pulses at beat 3 (ignored) and in the cycle done is high (accepted). Expect one uninterrupted scan followed immediately by a second full scan.
- COLS=1, ROWS=1, cell=1. Expect a single beat: out_bit=1, x=0, y=0, out_last=1, then done.
